// File: rtl/sync_byte_decoder.sv
// Receive-side decoder for the inter-board sync byte: link health FSM,
// enemy click pulses, enemy start level and the shooter-role latch.
module sync_byte_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SYNC_COUNT     = 4,
  parameter int unsigned MAX_ERR        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       local_game_starts,
  input  logic       role_clear,
  output logic       connect_corrected,
  output logic       enemy_left_click,
  output logic       enemy_right_click,
  output logic       enemy_game_starts,
  output logic       enemy_shooter
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned OW = $clog2(SYNC_COUNT + 1);
  localparam int unsigned EW = $clog2(MAX_ERR + 1);

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CODE_LEFT  = 8'hC8;
  localparam logic [7:0]    CODE_RIGHT = 8'h28;
  localparam logic [7:0]    CODE_START = 8'h48;
  localparam logic [7:0]    CODE_IDLE  = 8'h08;

  typedef enum logic [1:0] {LOST, SYNCING, LINKED} state_t;

  state_t        state;
  logic [OW-1:0] ok_cnt;
  logic [EW-1:0] err_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    prev_code;
  logic          role_set;

  logic       code_ok, good, bad, timeout, lose, enter_link;
  logic [7:0] cur_code;

  always_comb begin
    code_ok    = (rx_data == CODE_LEFT) || (rx_data == CODE_RIGHT) ||
                 (rx_data == CODE_START) || (rx_data == CODE_IDLE);
    good       = rx_valid && code_ok;
    bad        = rx_valid && !code_ok;
    timeout    = !good && (to_cnt == TO_LAST);
    enter_link = (state == SYNCING) && good && (ok_cnt == OW'(SYNC_COUNT - 1));
    lose       = ((state == SYNCING) && (bad || timeout)) ||
                 ((state == LINKED) && (timeout || (bad && (err_cnt == EW'(MAX_ERR - 1)))));
    cur_code   = good ? rx_data : prev_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= LOST;
      ok_cnt            <= '0;
      err_cnt           <= '0;
      to_cnt            <= '0;
      prev_code         <= CODE_IDLE;
      role_set          <= 1'b0;
      connect_corrected <= 1'b0;
      enemy_left_click  <= 1'b0;
      enemy_right_click <= 1'b0;
      enemy_game_starts <= 1'b0;
      enemy_shooter     <= 1'b0;
    end else begin
      enemy_left_click  <= 1'b0;
      enemy_right_click <= 1'b0;

      if (good)
        to_cnt <= '0;
      else if (to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;

      if (lose) begin
        state             <= LOST;
        ok_cnt            <= '0;
        err_cnt           <= '0;
        prev_code         <= CODE_IDLE;
        role_set          <= 1'b0;
        enemy_shooter     <= 1'b0;
        connect_corrected <= 1'b0;
        enemy_game_starts <= 1'b0;
      end else begin
        if (good)
          prev_code <= rx_data;
        connect_corrected <= (state == LINKED) || enter_link;
        enemy_game_starts <= ((state == LINKED) || enter_link) && (cur_code == CODE_START);

        // Roles are only assigned while the link is up; local START wins a tie.
        if (role_clear) begin
          role_set      <= 1'b0;
          enemy_shooter <= 1'b0;
        end else if ((state == LINKED) && !role_set) begin
          if (local_game_starts) begin
            role_set      <= 1'b1;
            enemy_shooter <= 1'b0;
          end else if (good && (rx_data == CODE_START)) begin
            role_set      <= 1'b1;
            enemy_shooter <= 1'b1;
          end
        end

        case (state)
          LOST: begin
            if (good) begin
              state  <= SYNCING;
              ok_cnt <= OW'(1);
            end
          end
          SYNCING: begin
            if (good) begin
              ok_cnt <= ok_cnt + 1'b1;
              if (enter_link)
                state <= LINKED;
            end
          end
          LINKED: begin
            if (good)
              err_cnt <= '0;
            else if (bad)
              err_cnt <= err_cnt + 1'b1;
            if (good && (rx_data != prev_code)) begin
              enemy_left_click  <= (rx_data == CODE_LEFT);
              enemy_right_click <= (rx_data == CODE_RIGHT);
            end
          end
          default: state <= LOST;
        endcase
      end
    end
  end

endmodule
